uart_fifo_rd_ctrl: RTL

- Read-side pointer and flag controller for the UART TX async FIFO. Lives in the read (UART baud/TX) clock domain.
- Sequences pops, drives the FIFO memory read address and produces empty, valid, level and underflow.
- Takes the write pointer after it has passed through the double-flop synchronizer (gray, ADDR_WIDTH+1 bits). Exports a registered gray read pointer for the write-side synchronizer.

---
 rtl/uart_fifo_rd_ctrl_if.sv | 38 +++
 rtl/uart_fifo_rd_ctrl.sv | 66 ++++++
 2 files changed

// File: rtl/uart_fifo_rd_ctrl_if.sv
// Read-side bundle between the UART TX FIFO read controller and its neighbours.
// The slave modport is the controller; the master modport is its user.
interface uart_fifo_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  localparam int PW = ADDR_WIDTH + 1;

  logic                  i_fifo_rd_en;
  logic [PW-1:0]         i_fifo_rd_wptr_sync;
  logic [ADDR_WIDTH-1:0] o_fifo_rd_addr;
  logic [PW-1:0]         o_fifo_rd_gptr;
  logic                  o_fifo_rd_empty;
  logic                  o_fifo_rd_valid;
  logic [PW-1:0]         o_fifo_rd_level;
  logic                  o_fifo_rd_underflow;

  modport slave (
    input  i_fifo_rd_en,
    input  i_fifo_rd_wptr_sync,
    output o_fifo_rd_addr,
    output o_fifo_rd_gptr,
    output o_fifo_rd_empty,
    output o_fifo_rd_valid,
    output o_fifo_rd_level,
    output o_fifo_rd_underflow
  );

  modport master (
    output i_fifo_rd_en,
    output i_fifo_rd_wptr_sync,
    input  o_fifo_rd_addr,
    input  o_fifo_rd_gptr,
    input  o_fifo_rd_empty,
    input  o_fifo_rd_valid,
    input  o_fifo_rd_level,
    input  o_fifo_rd_underflow
  );
endinterface

// File: rtl/uart_fifo_rd_ctrl.sv
// Read-side pointer/flag controller for the UART TX async FIFO.
// Consumes the synchronized gray write pointer and publishes a registered gray read pointer.
module uart_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                 i_fifo_rd_clk,
  input  logic                 i_fifo_rd_rst_n,
  uart_fifo_rd_ctrl_if.slave   bus
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] rbin_reg;
  logic [PW-1:0] rgray_reg;
  logic          empty_reg;
  logic          valid_reg;
  logic [PW-1:0] level_reg;
  logic          underflow_reg;

  logic          accept;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin_s;
  logic          empty_next;
  logic [PW-1:0] level_next;

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_wbin
      assign wbin_s[gi] = ^bus.i_fifo_rd_wptr_sync[PW-1:gi];
    end
  endgenerate

  always_comb begin
    accept     = bus.i_fifo_rd_en & ~empty_reg;
    rbin_next  = rbin_reg + {{(PW-1){1'b0}}, accept};
    rgray_next = rbin_next ^ (rbin_next >> 1);
    // Compare against the post-pop pointer so the last pop raises empty at its own edge.
    empty_next = (rgray_next == bus.i_fifo_rd_wptr_sync);
    level_next = wbin_s - rbin_next;
  end

  always_ff @(posedge i_fifo_rd_clk) begin
    if (!i_fifo_rd_rst_n) begin
      rbin_reg      <= '0;
      rgray_reg     <= '0;
      empty_reg     <= 1'b1;
      valid_reg     <= 1'b0;
      level_reg     <= '0;
      underflow_reg <= 1'b0;
    end else begin
      rbin_reg      <= rbin_next;
      rgray_reg     <= rgray_next;
      empty_reg     <= empty_next;
      valid_reg     <= accept;
      level_reg     <= level_next;
      underflow_reg <= bus.i_fifo_rd_en & empty_reg;
    end
  end

  assign bus.o_fifo_rd_addr      = rbin_reg[ADDR_WIDTH-1:0];
  assign bus.o_fifo_rd_gptr      = rgray_reg;
  assign bus.o_fifo_rd_empty     = empty_reg;
  assign bus.o_fifo_rd_valid     = valid_reg;
  assign bus.o_fifo_rd_level     = level_reg;
  assign bus.o_fifo_rd_underflow = underflow_reg;
endmodule
